mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesisable, parametrised self-checking monitor for the processor data-memory write port.
- Holds a loadable table of expected writes, which must occur in order, plus a table of tolerated "don't-care" addresses.
- Watches each write strobe and reports pass, fail or timeout with diagnostic capture.
- Sits beside the processor in simulation and on-FPGA bring-up. It replaces per-program hard-coded checks.

Parameters:
- ADDR_W, 32, width of the data address.
- DATA_W, 32, width of the write data.
- NUM_EXPECT, 8, depth of the ordered expected-write table.
- NUM_IGNORE, 4, depth of the tolerated-address table.
- TIMEOUT, 1000, RUN cycles allowed before a timeout failure. Must be ≥ 1.
- CNT_W, 16, width of the cycle counter. Must be wide enough to hold TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- clear  in  1  synchronous; returns to IDLE and empties both tables.
- load_valid  in  1  writes one table entry; accepted in IDLE only.
- load_kind  in  1  0 = expected write (addr+data), 1 = ignore address (data unused).
- load_addr  in  ADDR_W  entry address.
- load_data  in  DATA_W  entry data.
- start  in  1  IDLE -> RUN.
- mem_write  in  1  processor write strobe.
- data_adr  in  ADDR_W  processor write address.
- write_data  in  DATA_W  processor write data.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout.
- fail_addr  out  ADDR_W  data_adr captured on a failing write; 0 on timeout.
- fail_data  out  DATA_W  write_data captured on a failing write; 0 on timeout.
- match_count  out  $clog2(NUM_EXPECT+1)  expected entries matched so far.
- cycles  out  CNT_W  RUN cycles elapsed; frozen once done.

Behaviour:
- Reset (async) and clear (sync): state IDLE; both tables empty; all outputs 0.
- clear has priority over every other input in every state.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL are sticky until clear or reset.

IDLE:
- load_valid with load_kind=0 writes the next expected slot.
- load_valid with load_kind=1 writes the next ignore slot.
- Loads beyond table depth are silently dropped; counts saturate.
- start with exp_cnt > 0 enters RUN; start with exp_cnt = 0 is ignored.
- load_valid and start in the same cycle: the entry is stored and counts toward the start condition.
- mem_write is ignored in IDLE.

RUN, on each edge:
- cycles increments by 1.
- If mem_write is high, compare against expected entry idx = match_count, in this priority order:
  (a) data_adr == exp_addr[idx] and write_data == exp_data[idx]: match_count++. If this was the last loaded entry, go to PASS.
  (b) data_adr == exp_addr[idx] with different data: go to FAIL, code 2.
  (c) data_adr equals any loaded ignore address: no action.
  (d) otherwise: go to FAIL, code 1.
- On FAIL from (b) or (d), capture fail_addr and fail_data.
- Ignore-table membership never overrides (a) or (b).
- If no terminal transition occurred and cycles reaches TIMEOUT on this edge: go to FAIL, code 3.
- A write evaluated on the same edge as the timeout takes precedence.
- load_valid and start are ignored outside IDLE.

Latency and visibility:
- All outputs are registered. pass, fail and fail_code are visible immediately after the edge that samples the deciding write.
- Comparisons are exact bit equality over the full ADDR_W and DATA_W.
- A repeated write of an already-matched entry is treated as unexpected unless its address is in the ignore table.

Test Plan:
1. Load expect (100,7) and ignore 96, then start. Writes: (96,0x55), then (100,7). Required: pass=1, fail_code=0, match_count=1, done=1, busy=0.
2. Same load, then write (100,6). Required: fail=1, fail_code=2, fail_addr=100, fail_data=6.
3. Same load, then write (104,1). Required: fail=1, fail_code=1, fail_addr=104.
4. TIMEOUT=20, expect (100,7), no writes. Required: fail=1 and fail_code=3 after the 20th RUN edge; cycles=20; fail_addr=0.
5. Load three expected entries (0x10,1), (0x14,2), (0x18,3). Write 0x14 first. Required: fail code 1, match_count=0. Repeat with the correct order. Required: pass, match_count=3.
6. Load NUM_EXPECT+1 entries; required: the last entry is dropped. Then assert reset asynchronously mid-RUN; required: all outputs 0 without waiting for a clock edge. Then start with no reload; required: state stays IDLE.

Source files
------------

// File: rtl/mem_write_checker.sv
// -----------------------------------------------------------------------------
// mem_write_checker
//
// Self-checking monitor for a processor data-memory write port. A table of
// expected writes (address + data) is loaded while IDLE, together with a table
// of tolerated "don't-care" addresses. After start, every write strobe is
// compared against the next expected entry in order; the checker ends in PASS
// once every loaded entry has been matched, or in FAIL on an unexpected
// address, a data mismatch or a timeout. PASS/FAIL hold until clear or reset.
//
// Ports
//   clk          system clock, rising-edge
//   reset        asynchronous active-high reset (clears everything)
//   clear        synchronous clear back to IDLE, empties both tables
//   load_valid   table write strobe (IDLE only)
//   load_kind    0 = expected write entry, 1 = ignore-address entry
//   load_addr    entry address
//   load_data    entry data (expected entries only)
//   start        IDLE -> RUN when at least one expected entry is loaded
//   mem_write    processor write strobe
//   data_adr     processor write address
//   write_data   processor write data
//   busy         high in RUN
//   done         high in PASS or FAIL
//   pass         high in PASS
//   fail         high in FAIL
//   fail_code    0 none, 1 unexpected address, 2 data mismatch, 3 timeout
//   fail_addr    write address captured on a failing write (0 on timeout)
//   fail_data    write data captured on a failing write (0 on timeout)
//   match_count  expected entries matched so far
//   cycles       RUN cycles elapsed, frozen once done
// -----------------------------------------------------------------------------
module mem_write_checker #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_EXPECT = 8,
    parameter int NUM_IGNORE = 4,
    parameter int TIMEOUT    = 1000,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              load_valid,
    input  logic                              load_kind,
    input  logic [ADDR_W-1:0]                 load_addr,
    input  logic [DATA_W-1:0]                 load_data,
    input  logic                              start,
    input  logic                              mem_write,
    input  logic [ADDR_W-1:0]                 data_adr,
    input  logic [DATA_W-1:0]                 write_data,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              fail,
    output logic [1:0]                        fail_code,
    output logic [ADDR_W-1:0]                 fail_addr,
    output logic [DATA_W-1:0]                 fail_data,
    output logic [$clog2(NUM_EXPECT+1)-1:0]   match_count,
    output logic [CNT_W-1:0]                  cycles
);

    // Count widths hold 0..depth; index widths address a slot.
    localparam int MC_W = $clog2(NUM_EXPECT + 1);
    localparam int IC_W = $clog2(NUM_IGNORE + 1);
    localparam int EI_W = (NUM_EXPECT > 1) ? $clog2(NUM_EXPECT) : 1;
    localparam int II_W = (NUM_IGNORE > 1) ? $clog2(NUM_IGNORE) : 1;

    localparam logic [MC_W-1:0]  EXP_MAX   = MC_W'(NUM_EXPECT);
    localparam logic [IC_W-1:0]  IGN_MAX   = IC_W'(NUM_IGNORE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ADDR    = 2'd1;
    localparam logic [1:0] CODE_DATA    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    // Registered state and tables
    logic [1:0]        state_r;
    logic [MC_W-1:0]   exp_cnt_r;
    logic [IC_W-1:0]   ign_cnt_r;
    logic [ADDR_W-1:0] exp_addr_r [NUM_EXPECT];
    logic [DATA_W-1:0] exp_data_r [NUM_EXPECT];
    logic [ADDR_W-1:0] ign_addr_r [NUM_IGNORE];

    // Next-state values
    logic [1:0]        state_nxt_s;
    logic [MC_W-1:0]   exp_cnt_nxt_s;
    logic [IC_W-1:0]   ign_cnt_nxt_s;
    logic [MC_W-1:0]   match_nxt_s;
    logic [CNT_W-1:0]  cycles_nxt_s;
    logic [1:0]        code_nxt_s;
    logic [ADDR_W-1:0] faddr_nxt_s;
    logic [DATA_W-1:0] fdata_nxt_s;
    logic              exp_we_s;
    logic              ign_we_s;
    logic              terminal_s;

    // Comparison helpers
    logic [EI_W-1:0]   exp_idx_s;
    logic [EI_W-1:0]   exp_wr_idx_s;
    logic [II_W-1:0]   ign_wr_idx_s;
    logic              addr_hit_s;
    logic              data_hit_s;
    logic              ign_hit_s;

    // Current expected slot is the one after the last matched entry; in RUN
    // match_count is always below exp_cnt so the truncation is lossless.
    assign exp_idx_s    = match_count[EI_W-1:0];
    assign exp_wr_idx_s = exp_cnt_r[EI_W-1:0];
    assign ign_wr_idx_s = ign_cnt_r[II_W-1:0];
    assign addr_hit_s   = (data_adr == exp_addr_r[exp_idx_s]);
    assign data_hit_s   = (write_data == exp_data_r[exp_idx_s]);

    // Ignore-table membership, restricted to slots that have been loaded.
    always_comb begin
        ign_hit_s = 1'b0;
        for (int i = 0; i < NUM_IGNORE; i++) begin
            ign_hit_s = ign_hit_s |
                        ((IC_W'(i) < ign_cnt_r) && (ign_addr_r[i] == data_adr));
        end
    end

    // Next-state, table-write and diagnostic-capture decisions.
    always_comb begin
        state_nxt_s   = state_r;
        exp_cnt_nxt_s = exp_cnt_r;
        ign_cnt_nxt_s = ign_cnt_r;
        match_nxt_s   = match_count;
        cycles_nxt_s  = cycles;
        code_nxt_s    = fail_code;
        faddr_nxt_s   = fail_addr;
        fdata_nxt_s   = fail_data;
        exp_we_s      = 1'b0;
        ign_we_s      = 1'b0;
        terminal_s    = 1'b0;

        if (clear) begin
            state_nxt_s   = ST_IDLE;
            exp_cnt_nxt_s = '0;
            ign_cnt_nxt_s = '0;
            match_nxt_s   = '0;
            cycles_nxt_s  = '0;
            code_nxt_s    = CODE_NONE;
            faddr_nxt_s   = '0;
            fdata_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Loads past table depth are dropped and counts saturate.
                    if (load_valid && (load_kind == 1'b0) && (exp_cnt_r < EXP_MAX)) begin
                        exp_we_s      = 1'b1;
                        exp_cnt_nxt_s = exp_cnt_r + MC_W'(1);
                    end else if (load_valid && (load_kind == 1'b1) && (ign_cnt_r < IGN_MAX)) begin
                        ign_we_s      = 1'b1;
                        ign_cnt_nxt_s = ign_cnt_r + IC_W'(1);
                    end else begin
                        exp_we_s = 1'b0;
                        ign_we_s = 1'b0;
                    end
                    // A load in the same cycle as start counts toward starting.
                    if (start && (exp_cnt_nxt_s != '0)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    cycles_nxt_s = cycles + CNT_W'(1);
                    if (mem_write && addr_hit_s && data_hit_s) begin
                        match_nxt_s = match_count + MC_W'(1);
                        if (match_nxt_s == exp_cnt_r) begin
                            state_nxt_s = ST_PASS;
                            terminal_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (mem_write && addr_hit_s) begin
                        state_nxt_s = ST_FAIL;
                        code_nxt_s  = CODE_DATA;
                        faddr_nxt_s = data_adr;
                        fdata_nxt_s = write_data;
                        terminal_s  = 1'b1;
                    end else if (mem_write && !ign_hit_s) begin
                        state_nxt_s = ST_FAIL;
                        code_nxt_s  = CODE_ADDR;
                        faddr_nxt_s = data_adr;
                        fdata_nxt_s = write_data;
                        terminal_s  = 1'b1;
                    end else begin
                        // No write, or a tolerated address: nothing to record.
                        state_nxt_s = ST_RUN;
                    end
                    // A deciding write on the timeout edge wins over the timeout.
                    if (!terminal_s && (cycles_nxt_s == TIMEOUT_C)) begin
                        state_nxt_s = ST_FAIL;
                        code_nxt_s  = CODE_TIMEOUT;
                        faddr_nxt_s = '0;
                        fdata_nxt_s = '0;
                    end else begin
                        code_nxt_s = code_nxt_s;
                    end
                end

                ST_PASS: begin
                    state_nxt_s = ST_PASS;
                end

                ST_FAIL: begin
                    state_nxt_s = ST_FAIL;
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and all status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            exp_cnt_r   <= '0;
            ign_cnt_r   <= '0;
            match_count <= '0;
            cycles      <= '0;
            fail_code   <= CODE_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            exp_cnt_r   <= exp_cnt_nxt_s;
            ign_cnt_r   <= ign_cnt_nxt_s;
            match_count <= match_nxt_s;
            cycles      <= cycles_nxt_s;
            fail_code   <= code_nxt_s;
            fail_addr   <= faddr_nxt_s;
            fail_data   <= fdata_nxt_s;
            busy        <= (state_nxt_s == ST_RUN);
            done        <= (state_nxt_s == ST_PASS) || (state_nxt_s == ST_FAIL);
            pass        <= (state_nxt_s == ST_PASS);
            fail        <= (state_nxt_s == ST_FAIL);
        end
    end

    // Expected and ignore table storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EXPECT; i++) begin
                exp_addr_r[i] <= '0;
                exp_data_r[i] <= '0;
            end
            for (int j = 0; j < NUM_IGNORE; j++) begin
                ign_addr_r[j] <= '0;
            end
        end else if (exp_we_s) begin
            exp_addr_r[exp_wr_idx_s] <= load_addr;
            exp_data_r[exp_wr_idx_s] <= load_data;
        end else if (ign_we_s) begin
            ign_addr_r[ign_wr_idx_s] <= load_addr;
        end else begin
            exp_addr_r <= exp_addr_r;
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NE  = 8;
    localparam int NI  = 4;
    localparam int TO  = 20;
    localparam int CW  = 16;
    localparam int MCW = $clog2(NE + 1);

    logic           clk = 1'b0;
    logic           reset, clear, load_valid, load_kind, start, mem_write;
    logic [AW-1:0]  load_addr, data_adr;
    logic [DW-1:0]  load_data, write_data;
    logic           busy, done, pass, fail;
    logic [1:0]     fail_code;
    logic [AW-1:0]  fail_addr;
    logic [DW-1:0]  fail_data;
    logic [MCW-1:0] match_count;
    logic [CW-1:0]  cycles;

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_EXPECT(NE), .NUM_IGNORE(NI),
        .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_kind(load_kind), .load_addr(load_addr), .load_data(load_data),
        .start(start), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .fail_addr(fail_addr),
        .fail_data(fail_data), .match_count(match_count), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ps;
        logic [1:0]    code;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
        logic [MCW-1:0] mc;
        logic [CW-1:0] cyc;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    // Test plan: raw load sequence and per-RUN-edge write schedule (index 1..TO)
    logic          ld_kind[$];
    logic [AW-1:0] ld_addr[$];
    logic [DW-1:0] ld_data[$];
    logic          w_en   [0:TO];
    logic [AW-1:0] w_addr [0:TO];
    logic [DW-1:0] w_data [0:TO];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic clear_plan();
        ld_kind.delete(); ld_addr.delete(); ld_data.delete();
        for (int k = 0; k <= TO; k++) begin
            w_en[k] = 1'b0; w_addr[k] = '0; w_data[k] = '0;
        end
    endtask

    task automatic add_load(input logic kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_kind.push_back(kind); ld_addr.push_back(a); ld_data.push_back(d);
    endtask

    task automatic add_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_en[k] = 1'b1; w_addr[k] = a; w_data[k] = d;
    endtask

    // Reference: outcome of a run, straight from the ordered-expectation rules.
    function automatic res_t model();
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        logic [AW-1:0] ia[$];
        res_t r;
        int   m;
        bit   ign;
        foreach (ld_kind[i]) begin
            if (ld_kind[i] == 1'b0 && ea.size() < NE) begin
                ea.push_back(ld_addr[i]); ed.push_back(ld_data[i]);
            end else if (ld_kind[i] == 1'b1 && ia.size() < NI) begin
                ia.push_back(ld_addr[i]);
            end
        end
        r = '0;
        m = 0;
        for (int k = 1; k <= TO; k++) begin
            if (w_en[k]) begin
                if (w_addr[k] == ea[m] && w_data[k] == ed[m]) begin
                    m++;
                    if (m == ea.size()) begin
                        r.ps = 1'b1; r.mc = MCW'(m); r.cyc = CW'(k); return r;
                    end
                end else if (w_addr[k] == ea[m]) begin
                    r.code = 2'd2; r.fa = w_addr[k]; r.fd = w_data[k];
                    r.mc = MCW'(m); r.cyc = CW'(k); return r;
                end else begin
                    ign = 1'b0;
                    foreach (ia[j]) if (ia[j] == w_addr[k]) ign = 1'b1;
                    if (!ign) begin
                        r.code = 2'd1; r.fa = w_addr[k]; r.fd = w_data[k];
                        r.mc = MCW'(m); r.cyc = CW'(k); return r;
                    end
                end
            end
        end
        r.code = 2'd3; r.mc = MCW'(m); r.cyc = CW'(TO);
        return r;
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_done", {63'd0, done}, 64'd0);
        chk("clear_match", {{(64-MCW){1'b0}}, match_count}, 64'd0);
    endtask

    // Issue loads, start, drive the write schedule; expectation goes to the scoreboard.
    task automatic run_case(input bit start_with_last);
        int p0;
        do_clear();
        foreach (ld_kind[i]) begin
            load_valid = 1'b1; load_kind = ld_kind[i];
            load_addr = ld_addr[i]; load_data = ld_data[i];
            start = start_with_last && (i == ld_kind.size() - 1);
            @(posedge clk); #1;
        end
        load_valid = 1'b0; start = 1'b0;
        if (!start_with_last) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        p0 = pops;
        exp_q.push_back(model());
        for (int k = 1; k <= TO + 3; k++) begin
            mem_write  = (k <= TO) ? w_en[k]   : 1'b0;
            data_adr   = (k <= TO) ? w_addr[k] : '0;
            write_data = (k <= TO) ? w_data[k] : '0;
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        chk("done_seen", 64'(pops - p0), 64'd1);
        exp_q.delete();
    endtask

    // Scoreboard monitor: compare on each rising edge of done.
    initial begin : monitor
        res_t e;
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 required no pending run");
                end else begin
                    e = exp_q.pop_front();
                    chk("pass", {63'd0, pass}, {63'd0, e.ps});
                    chk("fail", {63'd0, fail}, {63'd0, ~e.ps});
                    chk("busy", {63'd0, busy}, 64'd0);
                    chk("fail_code", {62'd0, fail_code}, {62'd0, e.code});
                    chk("fail_addr", {32'd0, fail_addr}, {32'd0, e.fa});
                    chk("fail_data", {32'd0, fail_data}, {32'd0, e.fd});
                    chk("match_count", {{(64-MCW){1'b0}}, match_count}, {{(64-MCW){1'b0}}, e.mc});
                    chk("cycles", {48'd0, cycles}, {48'd0, e.cyc});
                end
                pops++;
            end
            done_q = done;
        end
    end

    initial begin : stimulus
        int g;
        int r;
        logic [AW-1:0] gea[$];
        logic [DW-1:0] ged[$];
        logic [AW-1:0] gia[$];
        reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_kind = 1'b0;
        load_addr = '0; load_data = '0; start = 1'b0; mem_write = 1'b0;
        data_adr = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_code", {62'd0, fail_code}, 64'd0);
        chk("rst_cycles", {48'd0, cycles}, 64'd0);

        // 1..3: expect (100,7), ignore 96
        for (int t = 0; t < 3; t++) begin
            clear_plan();
            add_load(1'b0, 32'd100, 32'd7);
            add_load(1'b1, 32'd96, 32'd0);
            if (t == 0) begin
                add_write(1, 32'd96, 32'h55); add_write(2, 32'd100, 32'd7);
            end else if (t == 1) begin
                add_write(1, 32'd100, 32'd6);
            end else begin
                add_write(1, 32'd104, 32'd1);
            end
            run_case(1'b0);
        end
        // 4: timeout
        clear_plan();
        add_load(1'b0, 32'd100, 32'd7);
        run_case(1'b0);
        // 5: out-of-order then in-order
        for (int t = 0; t < 2; t++) begin
            clear_plan();
            add_load(1'b0, 32'h10, 32'd1);
            add_load(1'b0, 32'h14, 32'd2);
            add_load(1'b0, 32'h18, 32'd3);
            if (t == 0) begin
                add_write(1, 32'h14, 32'd2);
            end else begin
                add_write(1, 32'h10, 32'd1); add_write(3, 32'h14, 32'd2);
                add_write(4, 32'h18, 32'd3);
            end
            run_case(1'b1);
        end

        // Randomized runs
        for (int n = 0; n < 40; n++) begin
            clear_plan();
            gea.delete(); ged.delete(); gia.delete();
            begin
                int ne, ni;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                ne = $urandom_range(1, NE + 1);
                ni = $urandom_range(0, NI + 1);
                while (ne + ni > 0) begin
                    a = AW'($urandom_range(0, 15)) << 2;
                    d = DW'($urandom_range(0, 3));
                    if (ne > 0 && (ni == 0 || $urandom_range(0, 1) == 0)) begin
                        add_load(1'b0, a, d);
                        if (gea.size() < NE) begin gea.push_back(a); ged.push_back(d); end
                        ne--;
                    end else begin
                        add_load(1'b1, a, d);
                        gia.push_back(a);
                        ni--;
                    end
                end
            end
            g = 0;
            for (int k = 1; k <= TO; k++) begin
                r = $urandom_range(0, 11);
                if (r < 6 && g < gea.size()) begin
                    add_write(k, gea[g], ged[g]); g++;
                end else if (r == 6 && g < gea.size()) begin
                    add_write(k, gea[g], ged[g] ^ 32'd1);
                end else if (r == 7 && gia.size() > 0) begin
                    add_write(k, gia[$urandom_range(0, gia.size() - 1)], DW'($urandom));
                end else if (r == 8) begin
                    add_write(k, AW'($urandom_range(0, 15)) << 2, DW'($urandom_range(0, 3)));
                end else if (r == 9 && g > 0) begin
                    add_write(k, gea[g-1], ged[g-1]);
                end
            end
            run_case($urandom_range(0, 1) == 1);
        end

        // 6a: NUM_EXPECT+1 loads; the ninth is dropped so eight matches pass
        clear_plan();
        for (int i = 0; i <= NE; i++) add_load(1'b0, 32'h100 + 32'(4 * i), 32'(i));
        for (int i = 0; i < NE; i++) add_write(i + 1, 32'h100 + 32'(4 * i), 32'(i));
        run_case(1'b0);

        // 6b: asynchronous reset in the middle of RUN
        do_clear();
        for (int i = 0; i <= NE; i++) begin
            load_valid = 1'b1; load_kind = 1'b0;
            load_addr = 32'h100 + 32'(4 * i); load_data = 32'(i);
            @(posedge clk); #1;
        end
        load_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_write = 1'b1; data_adr = 32'h100 + 32'(4 * i); write_data = 32'(i);
            @(posedge clk); #1;
        end
        mem_write = 1'b0;
        chk("mid_busy", {63'd0, busy}, 64'd1);
        chk("mid_match", {{(64-MCW){1'b0}}, match_count}, 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_match", {{(64-MCW){1'b0}}, match_count}, 64'd0);
        chk("async_cycles", {48'd0, cycles}, 64'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_empty_busy", {63'd0, busy}, 64'd0);
        chk("start_empty_cycles", {48'd0, cycles}, 64'd0);

        // Start with only ignore entries loaded stays IDLE
        do_clear();
        load_valid = 1'b1; load_kind = 1'b1; load_addr = 32'd96; start = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("start_ign_only", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
